instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 101 ++++++++++
 tb/tb_instruction_fetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: prefetching fetch unit with instruction FIFO, redirect flush and in-flight discard.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects park the unit in FAULT instead of being truncated.
module instruction_fetch #(
    parameter logic [0:31] RESET_ADDRESS = 32'h0000_0100,
    parameter int FIFO_DEPTH = 4,
    parameter int RS_ID_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [0:31] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [0:31] mem_resp_data,
    input  logic        redirect_valid,
    input  logic [0:31] redirect_addr,
    output logic        instruction_valid,
    input  logic        instruction_ready,
    output logic [0:31] instruction,
    output logic [0:31] instruction_address
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {FETCH, FAULT} state_t;

    state_t state, next_state;
    logic [0:31] pc, resp_pc, target;
    logic [CW-1:0] count, outstanding, discard, out_after;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [0:31] fifo_data [FIFO_DEPTH];
    logic [0:31] fifo_addr [FIFO_DEPTH];
    logic misaligned, req_fire, push, pop;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RS_ID_WIDTH < 1) begin : g_bad_param
        $error("instruction_fetch: FIFO_DEPTH must be a power of two in 2..16");
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = |redirect_addr[30:31];
    assign target = redirect_addr;
`else
    assign misaligned = 1'b0;
    assign target = redirect_addr & 32'hFFFF_FFFC;
`endif

    assign req_fire = mem_req_valid & mem_req_ready;
    assign pop = instruction_valid & instruction_ready;
    // Responses only enter the FIFO once every pre-redirect request has drained
    assign push = mem_resp_valid & ~redirect_valid & (discard == '0);
    assign out_after = outstanding - CW'(mem_resp_valid);
    assign instruction_valid = count != '0;
    assign instruction = instruction_valid ? fifo_data[rd_ptr] : '0;
    assign instruction_address = instruction_valid ? fifo_addr[rd_ptr] : '0;
    assign mem_req_addr = pc;

    always_comb begin
        next_state = redirect_valid ? (misaligned ? FAULT : FETCH) : state;
        mem_req_valid = rst && state == FETCH && !redirect_valid && discard == '0 &&
                        ({1'b0, count} + {1'b0, outstanding}) < (CW + 1)'(FIFO_DEPTH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
            pc <= RESET_ADDRESS;
            resp_pc <= RESET_ADDRESS;
            count <= '0;
            outstanding <= '0;
            discard <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= next_state;
            if (redirect_valid) begin
                pc <= target;
                resp_pc <= target;
                count <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                outstanding <= out_after;
                discard <= out_after;
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                if (push) resp_pc <= resp_pc + 32'd4;
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
                outstanding <= out_after + CW'(req_fire);
                if (mem_resp_valid && discard != '0) discard <= discard - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_resp_data;
            fifo_addr[wr_ptr] <= resp_pc;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench with a variable-latency in-order memory model.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        instruction_valid, instruction_ready;
    logic [31:0] instruction, instruction_address;

    int checks = 0, errs = 0, req_cnt = 0, pop_cnt = 0, mem_lat = 1, cyc = 0;
    int n, p0, r0;
    bit found;
    logic [31:0] exp_q[$], exp_req_q[$], mq_addr[$];
    int mq_due[$];
    logic fire_seen = 1'b0;
    logic [31:0] fire_addr = '0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
        .instruction(instruction), .instruction_address(instruction_address)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_from(input logic [31:0] a);
        exp_q.delete();
        exp_req_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(a + 32'(4 * i));
            exp_req_q.push_back(a + 32'(4 * i));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        redirect_valid = 1'b0;
        expect_from(32'h100);
        repeat (2) @(negedge clk);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(instruction_valid), 32'd0);
        check("rst_req_addr", mem_req_addr, 32'h100);
        check("rst_inst", instruction, 32'd0);
        check("rst_inst_addr", instruction_address, 32'd0);
        tick();
        rst = 1'b1;
    endtask

    // Caller sits just after a rising edge; redirect lasts exactly one cycle
    task automatic do_redirect(input logic [31:0] a, input logic [31:0] start, input bit stream);
        redirect_valid = 1'b1;
        redirect_addr = a;
        tick();
        redirect_valid = 1'b0;
        exp_q.delete();
        exp_req_q.delete();
        if (stream) expect_from(start);
        @(negedge clk);
        check("flush_valid", 32'(instruction_valid), 32'd0);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_resp_valid <= 1'b0;
            mem_resp_data <= '0;
            cyc <= 0;
            mq_addr.delete();
            mq_due.delete();
        end else begin
            cyc <= cyc + 1;
            if (fire_seen) begin
                mq_addr.push_back(fire_addr);
                mq_due.push_back(cyc + mem_lat);
            end
            mem_resp_valid <= 1'b0;
            if (mq_due.size() != 0 && mq_due[0] <= cyc + 1) begin
                mem_resp_valid <= 1'b1;
                mem_resp_data <= word_of(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        fire_seen <= rst && mem_req_valid && mem_req_ready;
        fire_addr <= mem_req_addr;
        if (rst && mem_req_valid && mem_req_ready) begin
            req_cnt <= req_cnt + 1;
            if (exp_req_q.size() == 0) check("req_extra", 32'(exp_req_q.size()), 32'd1);
            else check("req_addr", mem_req_addr, exp_req_q.pop_front());
        end
        if (rst && instruction_valid && instruction_ready) begin
            pop_cnt <= pop_cnt + 1;
            if (exp_q.size() == 0) check("inst_extra", 32'(exp_q.size()), 32'd1);
            else begin
                e = exp_q.pop_front();
                check("inst_addr", instruction_address, e);
                check("inst_data", instruction, word_of(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        instruction_ready = 1'b1;
        mem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        // Streaming from reset: 0x100, 0x104, ... at one instruction per cycle
        do_reset();
        for (int i = 0; i < 20 && !instruction_valid; i++) @(negedge clk);
        check("t1_first_valid", 32'(instruction_valid), 32'd1);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            n += int'(instruction_valid && instruction_ready);
        end
        check("t1_rate", n, 8);
        // Decode stalled: buffer fills with exactly FIFO_DEPTH requests
        tick();
        instruction_ready = 1'b0;
        do_reset();
        r0 = req_cnt;
        repeat (10) @(negedge clk);
        check("t2_reqs", req_cnt - r0, 4);
        check("t2_req_valid", 32'(mem_req_valid), 32'd0);
        check("t2_inst_valid", 32'(instruction_valid), 32'd1);
        check("t2_head", instruction_address, 32'h100);
        tick();
        instruction_ready = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            n += int'(instruction_valid && instruction_ready);
        end
        check("t2_drain_rate", n, 8);
        // Redirect with three requests in flight on a slow memory
        tick();
        mem_lat = 5;
        do_reset();
        r0 = req_cnt;
        repeat (3) tick();
        check("t3_inflight", req_cnt - r0, 3);
        do_redirect(32'h2000, 32'h2000, 1'b1);
        check("t3_discard_block", 32'(mem_req_valid), 32'd0);
        p0 = pop_cnt;
        for (int i = 0; i < 60 && pop_cnt == p0; i++) @(negedge clk);
        check("t3_resumed", 32'(pop_cnt != p0), 32'd1);
        // Redirect coinciding with a pop and a response
        tick();
        mem_lat = 1;
        repeat (10) tick();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = mem_resp_valid && instruction_valid && instruction_ready;
        end
        check("t4_cond", 32'(found), 32'd1);
        do_redirect(32'h3000, 32'h3000, 1'b1);
        p0 = pop_cnt;
        repeat (10) @(negedge clk);
        check("t4_resumed", 32'(pop_cnt - p0 >= 5), 32'd1);
        // PC wraps from 0xFFFF_FFFC to 0
        tick();
        do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b1);
        p0 = pop_cnt;
        repeat (12) @(negedge clk);
        check("t5_wrap_pops", 32'(pop_cnt - p0 >= 5), 32'd1);
        // Misaligned redirect
        tick();
        r0 = req_cnt;
`ifdef FETCH_ALIGN_CHECK_EN
        do_redirect(32'h2002, 32'h0, 1'b0);
        repeat (10) @(negedge clk);
        check("t6_no_req", req_cnt - r0, 0);
        check("t6_req_valid", 32'(mem_req_valid), 32'd0);
        tick();
        do_redirect(32'h3000, 32'h3000, 1'b1);
`else
        do_redirect(32'h2002, 32'h2000, 1'b1);
`endif
        p0 = pop_cnt;
        repeat (10) @(negedge clk);
        check("t6_resumed", 32'(pop_cnt - p0 >= 4), 32'd1);
        tick();
        $display("%0d/%0d checks passed", checks - errs, checks);
        $finish;
    end
endmodule
